// File: rtl/rx_link_ctrl.sv
// rtl/rx_link_ctrl.sv - two-lane receive link sequencer with per-lane 2-entry FIFOs and round-robin byte merge
// Optional feature: RX_LINK_CTRL_ERRCNT_EN enables the saturating err_cnt counter.
module rx_link_ctrl #(
    parameter int TIMEOUT     = 32,
    parameter int RETRAIN_CYC = 2
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_rx0,
    input  logic [7:0] data_rx1,
    input  logic       valid_rx0,
    input  logic       valid_rx1,
    input  logic       active0,
    input  logic       active1,
    output logic [1:0] lane_rst_n,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       lane_id,
    input  logic       ready_out,
    output logic       link_up,
    output logic [1:0] state,
    output logic [7:0] err_cnt
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_TRAIN   = 2'd1,
        S_UP      = 2'd2,
        S_RETRAIN = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [7:0]           timer_q, timer_d;
    logic [3:0]           rcnt_q, rcnt_d;
    logic                 flush;
    logic                 both_active;

    logic [1:0][1:0][7:0] mem_q, mem_d;
    logic [1:0]           rd_q, rd_d;
    logic [1:0][1:0]      cnt_q, cnt_d;
    logic [1:0][7:0]      din;
    logic [1:0]           push, pop, full, nonempty;
    logic                 grant;

    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 lane_q, lane_d;
    logic                 last_q, last_d;

    assign both_active = active0 & active1;
    assign din         = {data_rx1, data_rx0};
    assign nonempty    = {cnt_q[1] != 2'd0, cnt_q[0] != 2'd0};
    assign full        = {cnt_q[1] == 2'd2, cnt_q[0] == 2'd2};
    assign push        = {valid_rx1, valid_rx0} & {2{(state_q == S_UP) && !flush}};

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        rcnt_d  = '0;
        flush   = 1'b0;
        case (state_q)
            S_IDLE:  state_d = S_TRAIN;
            S_TRAIN: begin
                if (both_active) begin
                    state_d = S_UP;
                end else if (timer_q == 8'(TIMEOUT - 1)) begin
                    state_d = S_RETRAIN;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_UP: begin
                if (!both_active) begin
                    state_d = S_RETRAIN;
                    flush   = 1'b1;
                end
            end
            S_RETRAIN: begin
                if (rcnt_q == 4'(RETRAIN_CYC - 1)) begin
                    state_d = S_TRAIN;
                end else begin
                    rcnt_d = rcnt_q + 4'd1;
                end
            end
        endcase
    end

    // Output register pops a FIFO head on load; a push into a full FIFO is only
    // accepted when that same FIFO pops, reusing the slot being read.
    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        lane_d  = lane_q;
        last_d  = last_q;
        pop     = '0;
        grant   = (nonempty == 2'b11) ? ~last_q : nonempty[1];
        if (!valid_q || ready_out) begin
            if (|nonempty) begin
                pop[grant] = 1'b1;
                data_d     = mem_q[grant][rd_q[grant]];
                lane_d     = grant;
                last_d     = grant;
                valid_d    = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
        for (int l = 0; l < 2; l++) begin
            if (pop[l]) begin
                rd_d[l]  = ~rd_q[l];
                cnt_d[l] = cnt_q[l] - 2'd1;
            end
            if (push[l] && (!full[l] || pop[l])) begin
                mem_d[l][rd_q[l] ^ cnt_q[l][0]] = din[l];
                cnt_d[l] = cnt_d[l] + 2'd1;
            end
        end
        if (flush) begin
            cnt_d   = '0;
            rd_d    = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            rcnt_q  <= '0;
            mem_q   <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            lane_q  <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            rcnt_q  <= rcnt_d;
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            lane_q  <= lane_d;
            last_q  <= last_d;
        end
    end

`ifdef RX_LINK_CTRL_ERRCNT_EN
    logic [7:0] err_q, err_d;
    logic       timeout_err, err_any;

    assign timeout_err = (state_q == S_TRAIN) && !both_active && (timer_q == 8'(TIMEOUT - 1));
    assign err_any     = timeout_err | flush | (|(push & full & ~pop));

    always_comb begin
        err_d = err_q;
        if (err_any && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = 8'h00;
`endif

    assign state      = state_q;
    assign link_up    = (state_q == S_UP);
    assign lane_rst_n = ((state_q == S_TRAIN) || (state_q == S_UP)) ? 2'b11 : 2'b00;
    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign lane_id    = lane_q;

endmodule

// File: tb/tb_rx_link_ctrl.sv
// tb/tb_rx_link_ctrl.sv - self-checking bench for rx_link_ctrl with a queue-based reference model
module tb_rx_link_ctrl;
    localparam int TIMEOUT     = 32;
    localparam int RETRAIN_CYC = 2;
`ifdef RX_LINK_CTRL_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk_4f = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_rx0 = '0, data_rx1 = '0;
    logic       valid_rx0 = 1'b0, valid_rx1 = 1'b0;
    logic       active0 = 1'b0, active1 = 1'b0;
    logic       ready_out = 1'b0;
    logic [1:0] lane_rst_n;
    logic [7:0] data_out;
    logic       valid_out;
    logic       lane_id;
    logic       link_up;
    logic [1:0] state;
    logic [7:0] err_cnt;

    always #5 clk_4f = ~clk_4f;

    rx_link_ctrl #(.TIMEOUT(TIMEOUT), .RETRAIN_CYC(RETRAIN_CYC)) dut (
        .clk_4f    (clk_4f),
        .reset     (reset),
        .data_rx0  (data_rx0),
        .data_rx1  (data_rx1),
        .valid_rx0 (valid_rx0),
        .valid_rx1 (valid_rx1),
        .active0   (active0),
        .active1   (active1),
        .lane_rst_n(lane_rst_n),
        .data_out  (data_out),
        .valid_out (valid_out),
        .lane_id   (lane_id),
        .ready_out (ready_out),
        .link_up   (link_up),
        .state     (state),
        .err_cnt   (err_cnt)
    );

    int total = 0;
    int bad = 0;

    // Reference model: state as a number, FIFOs as queues.
    int         m_state, m_timer, m_rcnt, m_err;
    bit         m_last, m_valid, m_lane;
    logic [7:0] m_data;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    logic [7:0] got_d[$];
    logic       got_l[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int ns;
        bit err, fl;
        int g;
        if (!reset) begin
            m_state = 0; m_timer = 0; m_rcnt = 0; m_err = 0;
            m_last = 1; m_valid = 0; m_lane = 0; m_data = 8'h00;
            q0.delete(); q1.delete();
            return;
        end
        ns = m_state; err = 0; fl = 0;
        case (m_state)
            0: ns = 1;
            1: if (active0 && active1) ns = 2;
               else if (m_timer == TIMEOUT - 1) begin ns = 3; err = 1; end
            2: if (!active0 || !active1) begin ns = 3; err = 1; fl = 1; end
            default: if (m_rcnt == RETRAIN_CYC - 1) ns = 1;
        endcase
        m_timer = (m_state == 1 && ns == 1) ? m_timer + 1 : 0;
        m_rcnt  = (m_state == 3 && ns == 3) ? m_rcnt + 1 : 0;
        if (!m_valid || ready_out) begin
            if (q0.size() > 0 && q1.size() > 0) g = m_last ? 0 : 1;
            else if (q0.size() > 0) g = 0;
            else if (q1.size() > 0) g = 1;
            else g = -1;
            if (g == 0) begin
                m_data = q0.pop_front(); m_lane = 0; m_last = 0; m_valid = 1;
            end else if (g == 1) begin
                m_data = q1.pop_front(); m_lane = 1; m_last = 1; m_valid = 1;
            end else begin
                m_valid = 0;
            end
        end
        if (m_state == 2 && !fl) begin
            if (valid_rx0) begin
                if (q0.size() < 2) q0.push_back(data_rx0); else err = 1;
            end
            if (valid_rx1) begin
                if (q1.size() < 2) q1.push_back(data_rx1); else err = 1;
            end
        end
        if (fl) begin
            q0.delete(); q1.delete(); m_valid = 0;
        end
        if (err && ERR_EN && m_err < 255) m_err++;
        m_state = ns;
    endtask

    task automatic compare();
        chk("state", state, m_state);
        chk("lane_rst_n", lane_rst_n, (m_state == 1 || m_state == 2) ? 3 : 0);
        chk("link_up", link_up, m_state == 2);
        chk("valid_out", valid_out, m_valid);
        chk("err_cnt", err_cnt, m_err);
        if (m_valid) begin
            chk("data_out", data_out, m_data);
            chk("lane_id", lane_id, m_lane);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_4f);
        #1;
        compare();
    endtask

    task automatic idle_inputs();
        valid_rx0 = 0; valid_rx1 = 0; data_rx0 = 0; data_rx1 = 0;
        active0 = 0; active1 = 0; ready_out = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        repeat (3) tick();
        reset = 1;
        tick();
    endtask

    task automatic go_up();
        int n;
        active0 = 1; active1 = 1;
        n = 0;
        while (state != 2'd2 && n < 20) begin
            tick();
            n++;
        end
        chk("reach_up", state, 2);
    endtask

    task automatic rec();
        if (valid_out) begin
            got_d.push_back(data_out);
            got_l.push_back(lane_id);
        end
    endtask

    initial begin
        logic [7:0] exp_rr[6];
        logic       exp_rl[6];
        logic [7:0] exp_bp[3];
        int n, r;
        exp_rr = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
        exp_rl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_bp = '{8'hA1, 8'hA2, 8'hA3};

        // Reset and training
        idle_inputs();
        reset = 0;
        repeat (3) tick();
        chk("rst_state", state, 0);
        chk("rst_lane_rst", lane_rst_n, 0);
        chk("rst_data", data_out, 0);
        chk("rst_valid", valid_out, 0);
        chk("rst_lane_id", lane_id, 0);
        chk("rst_err", err_cnt, 0);
        reset = 1;
        tick();
        chk("train_state", state, 1);
        chk("train_lane_rst", lane_rst_n, 2'b11);
        repeat (3) tick();
        active0 = 1; active1 = 1;
        tick();
        chk("up_state", state, 2);
        chk("up_link", link_up, 1);
        chk("up_err", err_cnt, 0);

        // Round-robin
        ready_out = 1;
        got_d.delete(); got_l.delete();
        for (int i = 0; i < 3; i++) begin
            valid_rx0 = 1; valid_rx1 = 1;
            data_rx0 = 8'(8'h10 + i);
            data_rx1 = 8'(8'h20 + i);
            tick();
            rec();
        end
        valid_rx0 = 0; valid_rx1 = 0;
        repeat (8) begin tick(); rec(); end
        chk("rr_count", got_d.size(), 6);
        for (int i = 0; i < 6 && i < got_d.size(); i++) begin
            chk("rr_data", got_d[i], exp_rr[i]);
            chk("rr_lane", got_l[i], exp_rl[i]);
        end

        // Backpressure with overflow on the fourth byte
        ready_out = 0;
        for (int i = 0; i < 4; i++) begin
            valid_rx0 = 1;
            data_rx0 = 8'(8'hA1 + i);
            tick();
        end
        valid_rx0 = 0;
        tick();
        chk("bp_hold_data", data_out, 8'hA1);
        chk("bp_hold_valid", valid_out, 1);
        chk("bp_err", err_cnt, ERR_EN ? 1 : 0);
        got_d.delete(); got_l.delete();
        rec();
        ready_out = 1;
        repeat (5) begin tick(); rec(); end
        chk("bp_count", got_d.size(), 3);
        for (int i = 0; i < 3 && i < got_d.size(); i++) chk("bp_data", got_d[i], exp_bp[i]);

        // Link drop with both FIFOs holding data
        ready_out = 0;
        repeat (2) begin
            valid_rx0 = 1; valid_rx1 = 1; data_rx0 = 8'h55; data_rx1 = 8'h66;
            tick();
        end
        valid_rx0 = 0; valid_rx1 = 0;
        active0 = 0;
        tick();
        chk("drop_valid", valid_out, 0);
        chk("drop_state", state, 3);
        chk("drop_lane_rst", lane_rst_n, 0);
        chk("drop_err", err_cnt, ERR_EN ? 2 : 0);
        go_up();
        tick();
        chk("drop_flushed", valid_out, 0);

        // Timeout
        do_reset();
        active0 = 1; active1 = 0;
        n = 0;
        while (state == 2'd1 && n < 100) begin n++; tick(); end
        chk("to_train_cycles", n, 32);
        r = 0;
        while (state == 2'd3 && r < 20) begin r++; tick(); end
        chk("to_retrain_cycles", r, 2);
        chk("to_state_after", state, 1);
        chk("to_err", err_cnt, ERR_EN ? 1 : 0);

        // Saturation
        do_reset();
        go_up();
        ready_out = 0;
        valid_rx0 = 1; data_rx0 = 8'h3C;
        repeat (300) tick();
        chk("sat_err", err_cnt, ERR_EN ? 8'hFF : 8'h00);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset     = ($urandom_range(0, 599) != 0);
            active0   = ($urandom_range(0, 63) != 0);
            active1   = ($urandom_range(0, 63) != 0);
            valid_rx0 = 1'($urandom_range(0, 1));
            valid_rx1 = 1'($urandom_range(0, 1));
            data_rx0  = 8'($urandom_range(0, 255));
            data_rx1  = 8'($urandom_range(0, 255));
            ready_out = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rx_link_ctrl.md
# rx_link_ctrl

Link controller for the two-lane receive path. Sequences the lane deserializers through reset, comma training and operation, and monitors each lane's `active` flag. Buffers each lane's parallel bytes in a 2-entry FIFO and merges both lanes into one byte stream by round-robin arbitration under a valid/ready handshake. Sits between the per-lane serial-to-parallel converters and the downstream byte consumer, all in the clk_4f domain.

## Interface
- `TIMEOUT`, default 32: clk_4f cycles allowed in TRAIN for both lanes to go active; valid range 4–255.
- `RETRAIN_CYC`, default 2: cycles the lanes are held in reset on retrain; valid range 1–15.

- `clk_4f`  in  1  byte clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low; reset applies while `reset`=0.
- `data_rx0` / `data_rx1`  in  8  parallel byte from lane 0 / lane 1 deserializer.
- `valid_rx0` / `valid_rx1`  in  1  byte on the lane is a data byte (not comma).
- `active0` / `active1`  in  1  lane has completed comma alignment.
- `lane_rst_n`  out  2  per-lane active-low reset to the deserializers; bit n = lane n.
- `data_out`  out  8  merged byte.
- `valid_out`  out  1  `data_out` holds a byte.
- `lane_id`  out  1  source lane of `data_out`.
- `ready_out`  in  1  consumer accepts `data_out` this cycle.
- `link_up`  out  1  FSM in UP.
- `state`  out  2  FSM encoding: IDLE=0, TRAIN=1, UP=2, RETRAIN=3.
- `err_cnt`  out  8  saturating error counter.

## Operation
- Reset values: `state`=IDLE, `lane_rst_n`=2'b00, `data_out`=0, `valid_out`=0, `lane_id`=0, `link_up`=0, `err_cnt`=0. Both FIFOs empty. Round-robin last-grant = lane 1.
- IDLE: `lane_rst_n`=00. Next cycle goes to TRAIN unconditionally.
- TRAIN: `lane_rst_n`=11. The 8-bit timer counts from 0.
  - `active0`&`active1` goes to UP.
  - Otherwise, timer == `TIMEOUT`-1 goes to RETRAIN and raises a timeout error.
- UP: `link_up`=1 and FIFO writes are enabled. A sampled `active0`=0 or `active1`=0 goes to RETRAIN, raises a link-drop error and flushes both FIFOs and the output register.
- RETRAIN: `lane_rst_n`=00 for `RETRAIN_CYC` cycles, then goes to TRAIN with the timer cleared.
- FIFO writes happen only in UP:
  - lane n pushes `data_rxn` when `valid_rxn`=1.
  - In every other state, inputs are ignored and FIFOs stay empty.
- FIFO overflow: push to a full FIFO with no pop in the same cycle drops the incoming byte and raises an overflow error. Push and pop on a full FIFO in the same cycle is legal and loses nothing.
- Output register loads when `valid_out`=0 or `ready_out`=1.
- Arbitration on a load:
  - Only one FIFO non-empty: that FIFO is granted.
  - Both non-empty: the lane not granted last is granted.
  - Neither non-empty: `valid_out` goes to 0.
  - The granted head pops into `data_out`/`lane_id`, `valid_out`=1, and last-grant updates.
- While `valid_out`=1 and `ready_out`=0, `data_out`, `lane_id` and `valid_out` hold stable.
- Errors in one cycle (any combination of timeout, link drop, overflow on either lane) increment `err_cnt` by exactly 1. `err_cnt` saturates at 8'hFF.

## Timing
- Reset release to TRAIN: IDLE for 1 cycle, then `lane_rst_n`=11 from the 2nd edge after `reset`=1.
- `active0`&`active1` sampled at edge k gives `state`=UP and `link_up`=1 after edge k.
- Byte latency: a byte pushed at edge k into an empty FIFO, with the output register free, appears on `data_out` with `valid_out`=1 after edge k+1.
- With `ready_out`=1 and one lane streaming, throughput is 1 byte/cycle.
- Link drop in UP at edge k: after edge k, `valid_out`=0, FIFOs are empty and `lane_rst_n`=00.
- `reset`=0 mid-operation takes priority over all other logic and restores all reset values at the next edge.

## Configuration
- `RX_LINK_CTRL_ERRCNT_EN` defined: `err_cnt` operates as described.
- Not defined: the counter logic is compiled out and `err_cnt` is tied to 8'h00. Overflow drops, retrain and flush behaviour are unchanged.

## Test plan
- Reset and training: hold `reset`=0 for 3 cycles, release, raise `active0`/`active1` at cycle 5. Required: `lane_rst_n`=11 from cycle 2, `link_up`=1 after cycle 5, `err_cnt`=0.
- Timeout: keep `active1`=0 with `TIMEOUT`=32. Required: RETRAIN after 32 TRAIN cycles, `lane_rst_n`=00 for 2 cycles, `err_cnt`=1, then TRAIN again.
- Round-robin: in UP with `ready_out`=1, drive lane 0 bytes 0x10,0x11,0x12 and lane 1 bytes 0x20,0x21,0x22 simultaneously. Required output order: 0x10,0x20,0x11,0x21,0x12,0x22, with `lane_id` alternating 0,1.
- Backpressure: hold `ready_out`=0 while lane 0 sends 0xA1,0xA2,0xA3,0xA4. Required: `data_out`=0xA1 holds stable, 0xA4 is dropped, `err_cnt`=1. After `ready_out`=1, the output is 0xA1,0xA2,0xA3.
- Link drop: deassert `active0` in UP with both FIFOs holding data. Required: `valid_out`=0 and FIFOs empty next cycle, `state`=RETRAIN, `err_cnt` +1.
- Saturation and macro off: force 300 overflow cycles. Required: `err_cnt`=8'hFF with the macro defined, 8'h00 without it.
